key_beep_ctrl: RTL and testbench



---
 rtl/key_beep_if.sv | 27 ++
 rtl/key_beep_ctrl.sv | 141 ++++++++++++++
 tb/tb_key_beep_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/key_beep_if.sv
// Key-to-buzzer link: debounced key strobe/level in, buzzer drive and status out.
// The master is the key-event source, and the slave is the beep controller.
interface key_beep_if #(
    parameter int PEND_W = 3
);
    logic              key_flag;
    logic              key_value;
    logic              beep;
    logic              busy;
    logic [PEND_W-1:0] pend_cnt;

    modport master (
        output key_flag,
        output key_value,
        input  beep,
        input  busy,
        input  pend_cnt
    );

    modport slave (
        input  key_flag,
        input  key_value,
        output beep,
        output busy,
        output pend_cnt
    );
endinterface

// File: rtl/key_beep_ctrl.sv
// Buffers debounced key presses in a saturating counter and plays one square-wave
// tone burst, followed by a silent gap, on the buzzer for each buffered press.
module key_beep_ctrl #(
    parameter int TONE_DIV    = 12500,
    parameter int BURST_CYC   = 5000000,
    parameter int GAP_CYC     = 2500000,
    parameter int PEND_W      = 3,
    parameter int BEEP_ACTIVE = 1
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    key_beep_if.slave  kb
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic              BEEP_ON    = (BEEP_ACTIVE != 0);
    localparam logic              BEEP_OFF   = ~BEEP_ON;
    localparam logic [31:0]       DIV_LAST   = 32'(TONE_DIV - 1);
    localparam logic [31:0]       BURST_LAST = 32'(BURST_CYC - 1);
    localparam logic [31:0]       GAP_LAST   = 32'(GAP_CYC - 1);
    localparam logic [PEND_W-1:0] PEND_MAX   = {PEND_W{1'b1}};

    state_t            state;
    logic [31:0]       dur_cnt;
    logic [31:0]       div_cnt;
    logic [31:0]       gap_cnt;
    logic [PEND_W-1:0] pend;
    logic              beep_q;
    logic              busy_q;

    logic              press;
    logic              tone_done;
    logic              gap_done;
    logic              burst_start;

    // A simultaneous press and burst start cancel; saturation drops the press.
    function automatic logic [PEND_W-1:0] pend_next(
        input logic [PEND_W-1:0] cur,
        input logic              inc,
        input logic              dec
    );
        logic [PEND_W-1:0] nxt;
        nxt = cur;
        if (inc && !dec) begin
            if (cur != PEND_MAX)
                nxt = cur + PEND_W'(1);
        end else if (dec && !inc) begin
            if (cur != '0)
                nxt = cur - PEND_W'(1);
        end
        return nxt;
    endfunction

    assign press       = kb.key_flag & ~kb.key_value;
    assign tone_done   = (state == TONE) && (dur_cnt == BURST_LAST);
    assign gap_done    = (state == GAP) && (gap_cnt == GAP_LAST);
    assign burst_start = (pend != '0) && ((state == IDLE) || gap_done);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            dur_cnt <= '0;
            div_cnt <= '0;
            gap_cnt <= '0;
            pend    <= '0;
            beep_q  <= BEEP_OFF;
            busy_q  <= 1'b0;
        end else begin
            pend <= pend_next(pend, press, burst_start);

            case (state)
                IDLE: begin
                    if (burst_start) begin
                        state   <= TONE;
                        busy_q  <= 1'b1;
                        beep_q  <= BEEP_ON;
                        dur_cnt <= '0;
                        div_cnt <= '0;
                        gap_cnt <= '0;
                    end
                end

                TONE: begin
                    // Burst length is fixed by dur_cnt, independent of the tone phase.
                    if (tone_done) begin
                        state   <= GAP;
                        beep_q  <= BEEP_OFF;
                        dur_cnt <= '0;
                        div_cnt <= '0;
                        gap_cnt <= '0;
                    end else begin
                        dur_cnt <= dur_cnt + 32'd1;
                        if (div_cnt == DIV_LAST) begin
                            div_cnt <= '0;
                            beep_q  <= ~beep_q;
                        end else begin
                            div_cnt <= div_cnt + 32'd1;
                        end
                    end
                end

                GAP: begin
                    if (gap_done) begin
                        gap_cnt <= '0;
                        if (burst_start) begin
                            state   <= TONE;
                            busy_q  <= 1'b1;
                            beep_q  <= BEEP_ON;
                            dur_cnt <= '0;
                            div_cnt <= '0;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                            beep_q <= BEEP_OFF;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 32'd1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    busy_q  <= 1'b0;
                    beep_q  <= BEEP_OFF;
                    dur_cnt <= '0;
                    div_cnt <= '0;
                    gap_cnt <= '0;
                end
            endcase
        end
    end

    assign kb.beep     = beep_q;
    assign kb.busy     = busy_q;
    assign kb.pend_cnt = pend;

endmodule

// File: tb/tb_key_beep_ctrl.sv
// Randomized and directed bench for key_beep_ctrl against a timeline model
// that tracks cycles since the current burst started plus the pending count.
module tb_key_beep_ctrl;
    localparam int TONE_DIV    = 2;
    localparam int BURST_CYC   = 8;
    localparam int GAP_CYC     = 4;
    localparam int PEND_W      = 2;
    localparam int BEEP_ACTIVE = 1;
    localparam int PMAX        = (1 << PEND_W) - 1;
    localparam int PERIOD_LEN  = BURST_CYC + GAP_CYC;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;

    key_beep_if #(.PEND_W(PEND_W)) kb ();

    key_beep_ctrl #(
        .TONE_DIV   (TONE_DIV),
        .BURST_CYC  (BURST_CYC),
        .GAP_CYC    (GAP_CYC),
        .PEND_W     (PEND_W),
        .BEEP_ACTIVE(BEEP_ACTIVE)
    ) dut (
        .sys_clk(sys_clk),
        .rst_n  (rst_n),
        .kb     (kb)
    );

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;

    // Model: m_phase = cycles since the current burst began, -1 when idle.
    int m_phase = -1;
    int m_pend  = 0;

    int exp_wave [12] = '{1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int m_beep();
        if (m_phase >= 0 && m_phase < BURST_CYC && ((m_phase / TONE_DIV) % 2 == 0))
            return BEEP_ACTIVE;
        return 1 - BEEP_ACTIVE;
    endfunction

    task automatic model_edge(input logic f, input logic v);
        bit press;
        bit start;
        press = f && !v;
        start = (m_pend > 0) && (m_phase < 0 || m_phase == PERIOD_LEN - 1);
        if (start) begin
            m_phase = 0;
        end else if (m_phase >= 0) begin
            m_phase++;
            if (m_phase == PERIOD_LEN)
                m_phase = -1;
        end
        if (press && !start && m_pend < PMAX)
            m_pend++;
        else if (start && !press)
            m_pend--;
    endtask

    task automatic model_reset();
        m_phase = -1;
        m_pend  = 0;
    endtask

    task automatic compare();
        chk("beep", int'(kb.beep), m_beep());
        chk("busy", int'(kb.busy), (m_phase >= 0) ? 1 : 0);
        chk("pend_cnt", int'(kb.pend_cnt), m_pend);
    endtask

    task automatic step(input logic f, input logic v);
        kb.key_flag  = f;
        kb.key_value = v;
        @(posedge sys_clk);
        if (rst_n)
            model_edge(f, v);
        else
            model_reset();
        #1;
        compare();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int high;
        int guard;
        logic f;
        logic v;

        kb.key_flag  = 1'b0;
        kb.key_value = 1'b0;
        rst_n        = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_beep", int'(kb.beep), 0);
        chk("rst_busy", int'(kb.busy), 0);
        chk("rst_pend", int'(kb.pend_cnt), 0);
        rst_n = 1'b1;
        repeat (3) step(1'b0, 1'b0);

        // Single press and its exact waveform.
        step(1'b1, 1'b0);
        chk("press_pend", int'(kb.pend_cnt), 1);
        for (int i = 1; i <= 13; i++) begin
            step(1'b0, 1'b0);
            if (i == 1) begin
                chk("start_busy", int'(kb.busy), 1);
                chk("start_pend", int'(kb.pend_cnt), 0);
            end
            if (i <= 12)
                chk("burst_wave", int'(kb.beep), exp_wave[i-1]);
            if (i == 13)
                chk("burst_end_busy", int'(kb.busy), 0);
        end

        // Release strobe is ignored.
        step(1'b1, 1'b1);
        chk("release_pend", int'(kb.pend_cnt), 0);
        chk("release_beep", int'(kb.beep), 0);
        chk("release_busy", int'(kb.busy), 0);
        repeat (2) step(1'b0, 1'b0);

        // Saturation: five presses, only four bursts.
        high = 0;
        step(1'b1, 1'b0);
        for (int i = 1; i <= 60; i++) begin
            step((i <= 7) && (i % 2 == 1), 1'b0);
            if (i == 7)
                chk("sat_pend", int'(kb.pend_cnt), 3);
            if (kb.beep)
                high++;
        end
        chk("sat_beep_high_cycles", high, 16);
        chk("sat_idle", int'(kb.busy), 0);

        // Press on the same edge as a GAP->TONE transition.
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        guard = 0;
        while (m_phase != PERIOD_LEN - 1 && guard < 100) begin
            step(1'b0, 1'b0);
            guard++;
        end
        chk("same_edge_reach", (guard < 100) ? 1 : 0, 1);
        step(1'b1, 1'b0);
        chk("same_edge_pend", int'(kb.pend_cnt), 2);
        chk("same_edge_busy", int'(kb.busy), 1);
        chk("same_edge_beep", int'(kb.beep), 1);
        repeat (40) step(1'b0, 1'b0);
        chk("same_edge_drain", int'(kb.busy), 0);

        // Asynchronous reset mid-tone.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        #2;
        chk("pre_rst_beep", int'(kb.beep), 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_beep", int'(kb.beep), 0);
        chk("async_rst_pend", int'(kb.pend_cnt), 0);
        chk("async_rst_busy", int'(kb.busy), 0);
        repeat (2) step(1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (20) step(1'b0, 1'b0);
        chk("post_rst_idle", int'(kb.busy), 0);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            f = ($urandom_range(0, 3) == 0);
            v = 1'($urandom_range(0, 1));
            step(f, v);
        end
        repeat (60) step(1'b0, 1'b0);
        chk("random_drain", int'(kb.busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
